// File: rtl/cgra_config_loader.sv
// cgra_config_loader
//
// Loads a PE block's configuration scan chain bit-serially from a host
// word stream. While it shifts, it captures the bits that leave the chain
// and returns them as readback words.
//
// Ports
//   clk          in   single clock; the loader and the chain shift on its rising edge
//   reset        in   asynchronous, active-low reset
//   start        in   begins a load while IDLE
//   clear_first  in   sampled with start; runs the chain-reset phase before loading
//   s_data       in   host config word, bit 0 shifted first
//   s_valid      in   s_data valid
//   s_ready      out  a word is accepted this cycle (LOAD state only)
//   cfg_reset    out  chain config_reset (held 2 cycles in CLEAR)
//   cfg_shift    out  chain shift enable / config_clk gate (registered)
//   cfg_in       out  chain config_in (registered)
//   cfg_out_in   in   chain config_out
//   rb_data      out  readback word, bit 0 = first bit out of the chain
//   rb_valid     out  one-cycle strobe for rb_data
//   busy         out  high whenever the FSM is not IDLE
//   done         out  one-cycle pulse at the end of a load
module cgra_config_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            clear_first,
  input  logic [WORD-1:0] s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            cfg_reset,
  output logic            cfg_shift,
  output logic            cfg_in,
  input  logic            cfg_out_in,
  output logic [WORD-1:0] rb_data,
  output logic            rb_valid,
  output logic            busy,
  output logic            done
);

  localparam int NW  = (CHAIN_LEN + WORD - 1) / WORD;
  localparam int R   = CHAIN_LEN - WORD * (NW - 1);
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;

  // Bit-counter value on the final shift edge of a full / final word.
  localparam logic [5:0] LAST_FULL = 6'(WORD - 1);
  localparam logic [5:0] LAST_PART = 6'(R - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q,     state_d;
  logic [5:0]      bitcnt_q,    bitcnt_d;
  logic [WCW-1:0]  wcnt_q,      wcnt_d;
  logic [WORD-1:0] sreg_q,      sreg_d;
  logic [WORD-1:0] rbsr_q,      rbsr_d;
  logic [WORD-1:0] rb_data_q,   rb_data_d;
  logic            rb_valid_q,  rb_valid_d;
  logic            cfg_shift_q, cfg_shift_d;
  logic            cfg_in_q,    cfg_in_d;

  logic            last_word;
  logic [5:0]      last_bit;

  assign last_word = (wcnt_q == WCW'(NW - 1));
  assign last_bit  = last_word ? LAST_PART : LAST_FULL;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    wcnt_d      = wcnt_q;
    sreg_d      = sreg_q;
    rbsr_d      = rbsr_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    cfg_shift_d = 1'b0;
    cfg_in_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bitcnt_d = '0;
        wcnt_d   = '0;
        if (start) begin
          state_d = clear_first ? S_CLEAR : S_LOAD;
        end
      end

      // The bit counter doubles as the 2-cycle chain-reset timer.
      S_CLEAR: begin
        if (bitcnt_q[0]) begin
          state_d  = S_LOAD;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + 6'd1;
        end
      end

      // Bit 0 goes straight to cfg_in so the first shift cycle follows
      // the handshake immediately; the rest waits in the shift register.
      S_LOAD: begin
        if (s_valid) begin
          state_d     = S_SHIFT;
          sreg_d      = s_data >> 1;
          cfg_in_d    = s_data[0];
          cfg_shift_d = 1'b1;
          bitcnt_d    = '0;
          rbsr_d      = '0;
        end
      end

      // Every edge here is a chain shift edge: capture config_out at the
      // position of the bit being shifted, so a short final word leaves its
      // upper readback bits at zero.
      S_SHIFT: begin
        rbsr_d[bitcnt_q[4:0]] = cfg_out_in;
        if (bitcnt_q == last_bit) begin
          rb_data_d  = rbsr_d;
          rb_valid_d = 1'b1;
          bitcnt_d   = '0;
          if (last_word) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            wcnt_d  = wcnt_q + WCW'(1);
          end
        end else begin
          cfg_shift_d = 1'b1;
          cfg_in_d    = sreg_q[0];
          sreg_d      = sreg_q >> 1;
          bitcnt_d    = bitcnt_q + 6'd1;
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        bitcnt_d = '0;
        wcnt_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      wcnt_q      <= '0;
      sreg_q      <= '0;
      rbsr_q      <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      cfg_shift_q <= 1'b0;
      cfg_in_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      wcnt_q      <= wcnt_d;
      sreg_q      <= sreg_d;
      rbsr_q      <= rbsr_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_in_q    <= cfg_in_d;
    end
  end

  assign s_ready   = (state_q == S_LOAD);
  assign cfg_reset = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cfg_shift = cfg_shift_q;
  assign cfg_in    = cfg_in_q;
  assign rb_data   = rb_data_q;
  assign rb_valid  = rb_valid_q;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Testbench for cgra_config_loader: three instances (CHAIN_LEN 40, 64, 1),
// each driving a behavioural scan-chain model looped back into cfg_out_in.
module tb_cgra_config_loader;

  logic        clk;
  logic        reset;
  logic        clear_first;
  logic [31:0] s_data;
  logic        s_valid;
  logic [2:0]  start_v;

  logic [2:0]  ready_v, crst_v, sh_v, in_v, outin_v, rbv_v, busy_v, done_v;
  logic [31:0] rb_v [3];

  // Behavioural chains: new bit enters at the top, config_out is bit 0.
  logic [63:0] ch0 = '0;
  logic [63:0] ch1 = '0;
  logic [63:0] ch2 = '0;

  cgra_config_loader #(.CHAIN_LEN(40), .WORD(32)) u_l40 (
    .clk(clk), .reset(reset), .start(start_v[0]), .clear_first(clear_first),
    .s_data(s_data), .s_valid(s_valid), .s_ready(ready_v[0]),
    .cfg_reset(crst_v[0]), .cfg_shift(sh_v[0]), .cfg_in(in_v[0]),
    .cfg_out_in(outin_v[0]), .rb_data(rb_v[0]), .rb_valid(rbv_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  cgra_config_loader #(.CHAIN_LEN(64), .WORD(32)) u_l64 (
    .clk(clk), .reset(reset), .start(start_v[1]), .clear_first(clear_first),
    .s_data(s_data), .s_valid(s_valid), .s_ready(ready_v[1]),
    .cfg_reset(crst_v[1]), .cfg_shift(sh_v[1]), .cfg_in(in_v[1]),
    .cfg_out_in(outin_v[1]), .rb_data(rb_v[1]), .rb_valid(rbv_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  cgra_config_loader #(.CHAIN_LEN(1), .WORD(32)) u_l1 (
    .clk(clk), .reset(reset), .start(start_v[2]), .clear_first(clear_first),
    .s_data(s_data), .s_valid(s_valid), .s_ready(ready_v[2]),
    .cfg_reset(crst_v[2]), .cfg_shift(sh_v[2]), .cfg_in(in_v[2]),
    .cfg_out_in(outin_v[2]), .rb_data(rb_v[2]), .rb_valid(rbv_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  always @(posedge clk) begin
    if (crst_v[0]) ch0 <= '0;
    else if (sh_v[0]) ch0 <= {24'd0, in_v[0], ch0[39:1]};
    if (crst_v[1]) ch1 <= '0;
    else if (sh_v[1]) ch1 <= {in_v[1], ch1[63:1]};
    if (crst_v[2]) ch2 <= '0;
    else if (sh_v[2]) ch2 <= {63'd0, in_v[2]};
  end

  assign outin_v = {ch2[0], ch1[0], ch0[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selected instance's outputs.
  logic [1:0]  sel;
  logic        m_ready, m_crst, m_shift, m_in, m_rbv, m_busy, m_done;
  logic [31:0] m_rb;
  assign m_ready = ready_v[sel];
  assign m_crst  = crst_v[sel];
  assign m_shift = sh_v[sel];
  assign m_in    = in_v[sel];
  assign m_rbv   = rbv_v[sel];
  assign m_busy  = busy_v[sel];
  assign m_done  = done_v[sel];
  assign m_rb    = rb_v[sel];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard
  bit          q_bits[$];
  logic [31:0] q_rb[$];
  logic [31:0] prev [3][2];
  logic [31:0] wbuf [2];
  bit          mon_en = 1'b0;
  int          n_shift, n_rbv, n_done;
  logic        prev_shift = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_shift) begin
        n_shift++;
        if (q_bits.size() == 0) chk("extra_shift", 32'd1, 32'd0);
        else chk("cfg_in", 32'(m_in), 32'(q_bits.pop_front()));
      end
      if (m_rbv) begin
        n_rbv++;
        if (q_rb.size() == 0) chk("extra_rb_valid", 32'd1, 32'd0);
        else chk("rb_data", m_rb, q_rb.pop_front());
      end
      if (m_done) begin
        n_done++;
        chk("done_after_last_shift", 32'(prev_shift), 32'd1);
        chk("rb_valid_with_done", 32'(m_rbv), 32'd1);
      end
      prev_shift = m_shift;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int s, input bit clr, input int len, input int gap,
                          input bit poke_shift, input bit poke_done);
    int nw, r, n, nb;
    logic [31:0] mask;
    nw = (len + 31) / 32;
    r  = len - 32 * (nw - 1);
    q_bits.delete();
    q_rb.delete();
    n_shift = 0;
    n_rbv   = 0;
    n_done  = 0;
    for (int i = 0; i < nw; i++) begin
      q_rb.push_back(clr ? 32'd0 : prev[s][i]);
      mask = (i == nw - 1 && r < 32) ? ((32'd1 << r) - 32'd1) : 32'hFFFF_FFFF;
      prev[s][i] = wbuf[i] & mask;
      nb = (i == nw - 1) ? r : 32;
      for (int b = 0; b < nb; b++) q_bits.push_back(wbuf[i][b]);
    end
    sel = 2'(s);
    mon_en = 1'b1;
    clear_first = clr;
    start_v[s] = 1'b1;
    tick();
    start_v = '0;
    chk("busy_after_start", 32'(m_busy), 32'd1);
    if (clr) begin
      for (int c = 0; c < 2; c++) begin
        chk("cfg_reset_in_clear", 32'(m_crst), 32'd1);
        chk("s_ready_in_clear", 32'(m_ready), 32'd0);
        tick();
      end
      chk("cfg_reset_after_clear", 32'(m_crst), 32'd0);
    end
    chk("s_ready_after_start", 32'(m_ready), 32'd1);
    for (int i = 0; i < nw; i++) begin
      n = 0;
      while (!m_ready && n < 100) begin
        tick();
        n++;
      end
      if (!m_ready) chk("s_ready_timeout", 32'd0, 32'd1);
      chk("bubble_no_shift", 32'(m_shift), 32'd0);
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("gap_no_shift", 32'(m_shift), 32'd0);
          chk("gap_busy", 32'(m_busy), 32'd1);
        end
      end
      s_data  = wbuf[i];
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      s_data  = $urandom();
      chk("shift_after_handshake", 32'(m_shift), 32'd1);
      if (poke_shift && i == 0) begin
        for (int k = 0; k < 5; k++) tick();
        start_v[s] = 1'b1;
        tick();
        start_v = '0;
        chk("start_in_shift_no_ready", 32'(m_ready), 32'd0);
      end
    end
    n = 0;
    while (!m_done && n < 100) begin
      tick();
      n++;
    end
    if (!m_done) chk("done_timeout", 32'd0, 32'd1);
    if (poke_done) start_v[s] = 1'b1;
    tick();
    start_v = '0;
    chk("busy_after_done", 32'(m_busy), 32'd0);
    if (poke_done) begin
      tick();
      chk("start_in_done_ignored", 32'(m_busy), 32'd0);
    end
    chk("shift_count", n_shift, len);
    chk("rb_valid_count", n_rbv, nw);
    chk("done_count", n_done, 1);
    chk("bits_left", q_bits.size(), 0);
    chk("rb_left", q_rb.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk(tag, {ready_v[k], crst_v[k], sh_v[k], in_v[k], rbv_v[k], busy_v[k], done_v[k]}, 32'd0);
      chk(tag, rb_v[k], 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    reset       = 1'b0;
    clear_first = 1'b0;
    s_data      = '0;
    s_valid     = 1'b0;
    start_v     = '0;
    sel         = 2'd0;
    for (int k = 0; k < 3; k++) begin
      prev[k][0] = '0;
      prev[k][1] = '0;
    end
    tick();
    tick();
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    tick();

    // Two-word load, chain starts empty
    wbuf[0] = 32'hA5A5_A5A5;
    wbuf[1] = 32'h0000_00C3;
    run_load(0, 1'b0, 40, 0, 1'b0, 1'b0);
    // Second load reads back the first (upper readback bits zero)
    wbuf[0] = 32'h1234_5678;
    wbuf[1] = 32'hFFFF_FF5A;
    run_load(0, 1'b0, 40, 0, 1'b0, 1'b0);
    // Clear phase: readback all zeros
    wbuf[0] = 32'hDEAD_BEEF;
    wbuf[1] = 32'h0000_0081;
    run_load(0, 1'b1, 40, 0, 1'b0, 1'b0);
    // Backpressure between words
    wbuf[0] = $urandom();
    wbuf[1] = $urandom();
    run_load(0, 1'b0, 40, 5, 1'b0, 1'b0);

    // Reset at bit 17 of word 0
    mon_en = 1'b0;
    sel = 2'd0;
    clear_first = 1'b0;
    start_v[0] = 1'b1;
    tick();
    start_v = '0;
    n = 0;
    while (!ready_v[0] && n < 100) begin
      tick();
      n++;
    end
    s_data  = 32'hCAFE_F00D;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("mid_shift_before_reset", 32'(sh_v[0]), 32'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_mid_shift");
    tick();
    chk_all_zero("reset_held");
    reset = 1'b1;
    tick();
    wbuf[0] = 32'h0F0F_3C3C;
    wbuf[1] = 32'h0000_0099;
    run_load(0, 1'b1, 40, 0, 1'b0, 1'b0);

    // Exact multiple of 32, ignored starts in SHIFT and in DONE
    wbuf[0] = 32'h8000_0001;
    wbuf[1] = 32'h7FFF_FFFE;
    run_load(1, 1'b0, 64, 0, 1'b1, 1'b1);
    wbuf[0] = $urandom();
    wbuf[1] = $urandom();
    run_load(1, 1'b0, 64, 0, 1'b1, 1'b0);

    // Single-bit chain
    wbuf[0] = 32'hFFFF_FFFF;
    wbuf[1] = '0;
    run_load(2, 1'b0, 1, 0, 1'b0, 1'b0);
    wbuf[0] = 32'h0000_0002;
    run_load(2, 1'b0, 1, 0, 1'b0, 1'b0);
    wbuf[0] = 32'h0000_0003;
    run_load(2, 1'b0, 1, 0, 1'b0, 1'b0);

    mon_en = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
